addsub_serial_resp: RTL and testbench

ADDSUB_SERIAL_RESP -- requirements
Module: addsub_serial_resp

---
 rtl/addsub_serial_resp.sv | 137 +++++++++++++
 tb/tb_addsub_serial_resp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_resp.sv
// Bit-serial adder/subtractor with a valid/ready request port and a
// valid/ready response port. One operation is in flight at a time.
// Each operation computes one result bit per clock, LSB first.
// Subtraction is formed as A + ~B + 1. flag_o carries the carry-out
// for an add and the borrow (A < B) for a subtract.
module addsub_serial_resp #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             flag_o,
    output logic             busy_o
);

    // The bit counter only has to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             flag_q, flag_d;

    logic             b_bit;
    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] acc_next;

    // Full-adder slice on the current LSBs of the shifting operand registers
    always_comb begin
        b_bit     = sel_q ? b_q[0] : ~b_q[0];
        sum_bit   = a_q[0] ^ b_bit ^ carry_q;
        carry_out = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
        acc_next  = {sum_bit, acc_q[WIDTH-1:1]};
    end

    // Next-state and datapath update; every register holds unless its state says otherwise
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        y_d     = y_q;
        flag_d  = flag_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sel_d   = sel_i;
                    cnt_d   = '0;
                    carry_d = ~sel_i;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    y_d     = acc_next;
                    flag_d  = sel_q ? carry_out : ~carry_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            flag_q  <= flag_d;
        end
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        y_o         = y_q;
        flag_o      = flag_q;
    end

endmodule

// File: tb/tb_addsub_serial_resp.sv
// Self-checking bench for addsub_serial_resp (WIDTH=4). It runs a table of
// directed vectors, a reset-in-flight sequence, and randomized operations
// that are checked against an arithmetic reference model.
module tb_addsub_serial_resp;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready_o;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sel_in = 1'b0;
    logic         rsp_valid_o;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] y_o;
    logic         flag_o;
    logic         busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        int           stall;
        bit           noisy;
        logic [W-1:0] y;
        logic         f;
    } vec_t;

    vec_t vecs[11];

    addsub_serial_resp #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .a_i        (a_in),
        .b_i        (b_in),
        .sel_i      (sel_in),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .y_o        (y_o),
        .flag_o     (flag_o),
        .busy_o     (busy_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to W bits
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                         output logic [W-1:0] y, output logic f);
        int r;
        r = sel ? (int'(a) + int'(b)) : (int'(a) - int'(b));
        y = W'(r);
        f = sel ? (r > MAXV) : (r < 0);
    endtask

    // One full transaction, called and returning at a falling edge with the DUT in IDLE
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                                 input int stall, input bit noisy,
                                 input logic [W-1:0] ey, input logic ef, input string tag);
        int lat;
        check({tag, " req_ready in idle"}, {31'd0, req_ready_o}, 32'd1);
        req_valid = 1'b1;
        a_in      = a;
        b_in      = b;
        sel_in    = sel;
        rsp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " busy after accept"}, {31'd0, busy_o}, 32'd1);
        check({tag, " req_ready in calc"}, {31'd0, req_ready_o}, 32'd0);
        lat = 0;
        while (!rsp_valid_o && lat < 4 * W + 10) begin
            if (noisy) begin
                req_valid = 1'b1;
                a_in      = W'($urandom);
                b_in      = W'($urandom);
                sel_in    = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, W);
        check({tag, " y"}, {28'd0, y_o}, {28'd0, ey});
        check({tag, " flag"}, {31'd0, flag_o}, {31'd0, ef});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " valid held"}, {31'd0, rsp_valid_o}, 32'd1);
            check({tag, " y held"}, {28'd0, y_o}, {28'd0, ey});
            check({tag, " flag held"}, {31'd0, flag_o}, {31'd0, ef});
            check({tag, " req_ready in done"}, {31'd0, req_ready_o}, 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput(tag, ey, ef);
    endtask

    // Post-handshake state: back in IDLE with the result still visible
    task automatic checkOutput(input string tag, input logic [W-1:0] ey, input logic ef);
        check({tag, " valid drop"}, {31'd0, rsp_valid_o}, 32'd0);
        check({tag, " req_ready back"}, {31'd0, req_ready_o}, 32'd1);
        check({tag, " busy drop"}, {31'd0, busy_o}, 32'd0);
        check({tag, " y kept in idle"}, {28'd0, y_o}, {28'd0, ey});
        check({tag, " flag kept in idle"}, {31'd0, flag_o}, {31'd0, ef});
    endtask

    initial begin
        logic [W-1:0] ra, rb, ey;
        logic         rs, ef;

        vecs[0]  = '{a: 4'd4,  b: 4'd2,  sel: 1'b1, stall: 0, noisy: 1'b0, y: 4'd6,  f: 1'b0};
        vecs[1]  = '{a: 4'd4,  b: 4'd2,  sel: 1'b0, stall: 0, noisy: 1'b0, y: 4'd2,  f: 1'b0};
        vecs[2]  = '{a: 4'd7,  b: 4'd3,  sel: 1'b0, stall: 0, noisy: 1'b0, y: 4'd4,  f: 1'b0};
        vecs[3]  = '{a: 4'd7,  b: 4'd3,  sel: 1'b1, stall: 0, noisy: 1'b0, y: 4'd10, f: 1'b0};
        vecs[4]  = '{a: 4'd15, b: 4'd1,  sel: 1'b1, stall: 0, noisy: 1'b0, y: 4'd0,  f: 1'b1};
        vecs[5]  = '{a: 4'd2,  b: 4'd4,  sel: 1'b0, stall: 1, noisy: 1'b0, y: 4'd14, f: 1'b1};
        vecs[6]  = '{a: 4'd9,  b: 4'd5,  sel: 1'b1, stall: 3, noisy: 1'b0, y: 4'd14, f: 1'b0};
        vecs[7]  = '{a: 4'd5,  b: 4'd5,  sel: 1'b0, stall: 0, noisy: 1'b0, y: 4'd0,  f: 1'b0};
        vecs[8]  = '{a: 4'd0,  b: 4'd0,  sel: 1'b0, stall: 0, noisy: 1'b0, y: 4'd0,  f: 1'b0};
        vecs[9]  = '{a: 4'd15, b: 4'd15, sel: 1'b1, stall: 2, noisy: 1'b0, y: 4'd14, f: 1'b1};
        vecs[10] = '{a: 4'd6,  b: 4'd3,  sel: 1'b1, stall: 1, noisy: 1'b1, y: 4'd9,  f: 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset valid", {31'd0, rsp_valid_o}, 32'd0);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset y", {28'd0, y_o}, 32'd0);
        check("reset flag", {31'd0, flag_o}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].stall, vecs[i].noisy,
                          vecs[i].y, vecs[i].f, $sformatf("vec%0d", i));
        end

        // rsp_ready asserted while idle must not matter
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle rsp_ready ignored", {31'd0, req_ready_o}, 32'd1);
        rsp_ready = 1'b0;

        // Reset after two bits of a subtract whose result would be nonzero
        req_valid = 1'b1;
        a_in      = 4'd12;
        b_in      = 4'd1;
        sel_in    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midreset valid", {31'd0, rsp_valid_o}, 32'd0);
        check("midreset y", {28'd0, y_o}, 32'd0);
        check("midreset flag", {31'd0, flag_o}, 32'd0);
        check("midreset busy", {31'd0, busy_o}, 32'd0);
        check("midreset req_ready", {31'd0, req_ready_o}, 32'd1);
        repeat (WIDTH_WAIT()) @(negedge clk);
        check("midreset no response", {31'd0, rsp_valid_o}, 32'd0);
        applyStimulus(4'd3, 4'd5, 1'b0, 0, 1'b0, 4'd14, 1'b1, "postreset");

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, ey, ef);
            applyStimulus(ra, rb, rs, int'($urandom_range(0, 3)), 1'($urandom), ey, ef,
                          $sformatf("rand%0d a=%0d b=%0d sel=%0d", i, ra, rb, rs));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    function automatic int WIDTH_WAIT();
        return W + 2;
    endfunction

endmodule
